// File: rtl/me_pkg.sv
// Shared types and sizes for the motion-estimation block scheduler.
// Word counts and address widths match the engine's write-side memories.
package me_pkg;

  localparam int CUR_WORDS = 32;
  localparam int REF_WORDS = 128;
  localparam int CA_WIDTH  = 5;
  localparam int RA_WIDTH  = 7;
  localparam int PIX_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    LOAD_REF,
    GO,
    WAIT,
    RESULT
  } state_e;

endpackage

// File: rtl/me_load_ctr.sv
// Memory write-side loader: word address counter with write strobe and
// a terminal-count flag raised on the last accepted word of a block.
module me_load_ctr #(
  parameter int AW    = me_pkg::CA_WIDTH,
  parameter int WORDS = me_pkg::CUR_WORDS,
  parameter int DW    = me_pkg::PIX_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          we,
  output logic          last
);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    we    = en & in_valid;
    last  = we && (cnt_q == AW'(WORDS - 1));
    cnt_d = cnt_q;
    if (we) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr  = cnt_q;
  assign wdata = en ? in_data : '0;

endmodule

// File: rtl/me_block_sched.sv
// Block scheduler: loads cur/ref memories per block, kicks the engine,
// waits for a fresh done edge (or timeout) and returns one result per block.
module me_block_sched #(
  parameter int D_WIDTH   = me_pkg::PIX_WIDTH,
  parameter int CUR_WORDS = me_pkg::CUR_WORDS,
  parameter int REF_WORDS = me_pkg::REF_WORDS,
  parameter int TIMEOUT   = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 num_blocks,
  input  logic [3:0]                  cfg_r,
  output logic                        busy,
  output logic                        job_done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [D_WIDTH-1:0]          in_data,
  output logic [me_pkg::CA_WIDTH-1:0] address_write_cur,
  output logic [D_WIDTH-1:0]          data_write_cur,
  output logic                        write_enable_cur,
  output logic [me_pkg::RA_WIDTH-1:0] address_write_ref,
  output logic [D_WIDTH-1:0]          data_write_ref,
  output logic                        write_enable_ref,
  output logic [3:0]                  r,
  output logic                        go,
  input  logic                        done,
  input  logic [7:0]                  m_i,
  input  logic [7:0]                  m_j,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [7:0]                  res_mi,
  output logic [7:0]                  res_mj,
  output logic [15:0]                 res_idx,
  output logic                        res_err
);
  import me_pkg::*;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [15:0]   nb_q, nb_d;
  logic [15:0]   blk_q, blk_d;
  logic [3:0]    r_q, r_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    mi_q, mi_d, mj_q, mj_d;
  logic          err_q, err_d;
  logic          job_done_q, job_done_d;
  logic          done_q, done_evt;
  logic          load_cur, load_ref, cur_last, ref_last;

  assign load_cur = (state_q == LOAD_CUR);
  assign load_ref = (state_q == LOAD_REF);

  me_load_ctr #(.AW(CA_WIDTH), .WORDS(CUR_WORDS), .DW(D_WIDTH)) u_cur_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (load_cur),
    .in_valid (in_valid),
    .in_data  (in_data),
    .addr     (address_write_cur),
    .wdata    (data_write_cur),
    .we       (write_enable_cur),
    .last     (cur_last)
  );

  me_load_ctr #(.AW(RA_WIDTH), .WORDS(REF_WORDS), .DW(D_WIDTH)) u_ref_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (load_ref),
    .in_valid (in_valid),
    .in_data  (in_data),
    .addr     (address_write_ref),
    .wdata    (data_write_ref),
    .we       (write_enable_ref),
    .last     (ref_last)
  );

  // Only a 0->1 transition counts, so a done level left over from the last block is ignored.
  assign done_evt = done & ~done_q;

  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    blk_d      = blk_q;
    r_d        = r_q;
    tmo_d      = tmo_q;
    mi_d       = mi_q;
    mj_d       = mj_q;
    err_d      = err_q;
    job_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_blocks != 16'd0) begin
            nb_d    = num_blocks;
            r_d     = cfg_r;
            blk_d   = 16'd0;
            state_d = LOAD_CUR;
          end else begin
            job_done_d = 1'b1;
          end
        end
      end
      LOAD_CUR: if (cur_last) state_d = LOAD_REF;
      LOAD_REF: if (ref_last) state_d = GO;
      GO: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Timeout fires on the cycle the counter would reach TIMEOUT-1; done wins a tie.
        if (done_evt) begin
          mi_d    = m_i;
          mj_d    = m_j;
          err_d   = 1'b0;
          state_d = RESULT;
        end else if (tmo_q == TW'(TIMEOUT - 2)) begin
          mi_d    = 8'd0;
          mj_d    = 8'd0;
          err_d   = 1'b1;
          state_d = RESULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          if (blk_q == nb_q - 16'd1) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            blk_d   = blk_q + 16'd1;
            state_d = LOAD_CUR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      blk_q      <= '0;
      r_q        <= '0;
      tmo_q      <= '0;
      mi_q       <= '0;
      mj_q       <= '0;
      err_q      <= 1'b0;
      job_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      blk_q      <= blk_d;
      r_q        <= r_d;
      tmo_q      <= tmo_d;
      mi_q       <= mi_d;
      mj_q       <= mj_d;
      err_q      <= err_d;
      job_done_q <= job_done_d;
      done_q     <= done;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = load_cur | load_ref;
  assign go        = (state_q == GO);
  assign res_valid = (state_q == RESULT);
  assign job_done  = job_done_q;
  assign r         = r_q;
  assign res_mi    = mi_q;
  assign res_mj    = mj_q;
  assign res_err   = err_q;
  assign res_idx   = blk_q;

endmodule

// File: doc/me_block_sched.md
Name: me_block_sched

Overview:
Block-level scheduler for the motion-estimation engine. Streams each block's current-block pixels (32 words) and reference-window pixels (128 words) from a valid/ready input into the engine's two write-side memories, and sets the search range r. It then pulses go, waits for the engine's done, and returns the best match (m_i, m_j) per block over a valid/ready result channel. It repeats for num_blocks blocks per job and sits between the system front end and the engine top.

Parameters:
D_WIDTH, 64, pixel word width (8 x 8-bit pixels)
CUR_WORDS, 32, words per current block; cur address width 5
REF_WORDS, 128, words per reference window; ref address width 7
TIMEOUT, 4096, max cycles to wait for done after go (minimum 2)

Ports:
clk  in  1  single clock; also drives the memories' write clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle job start request
num_blocks  in  16  blocks in the job, sampled on accepted start
cfg_r  in  4  search range, sampled on accepted start
busy  out  1  job in progress
job_done  out  1  one-cycle pulse when the job finishes
in_valid  in  1  input pixel word valid
in_ready  out  1  scheduler accepts a pixel word
in_data  in  D_WIDTH  pixel word: cur words first, then ref words
address_write_cur  out  5  cur memory write address
data_write_cur  out  D_WIDTH  cur memory write data
write_enable_cur  out  1  cur memory write strobe
address_write_ref  out  7  ref memory write address
data_write_ref  out  D_WIDTH  ref memory write data
write_enable_ref  out  1  ref memory write strobe
r  out  4  search range to engine, held for the whole job
go  out  1  one-cycle engine start pulse
done  in  1  engine completion (level)
m_i  in  8  engine best-match row offset
m_j  in  8  engine best-match column offset
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_mi  out  8  captured m_i
res_mj  out  8  captured m_j
res_idx  out  16  block index of the result, starting at 0
res_err  out  1  result produced by timeout; res_mi = res_mj = 0

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; done_q 0.
- States: IDLE, LOAD_CUR, LOAD_REF, GO, WAIT, RESULT.
- IDLE:
  - start is accepted only in IDLE. On acceptance, latch num_blocks and cfg_r, clear blk_idx, and go to LOAD_CUR.
  - If num_blocks == 0, stay in IDLE and pulse job_done on the next cycle.
- start while busy is ignored; no queuing.
- busy = (state != IDLE).
- in_ready = 1 in LOAD_CUR and LOAD_REF only. Data path is combinational, zero latency:
  - write_enable_cur = in_valid & in_ready in LOAD_CUR; address_write_cur = word counter; data_write_cur = in_data. Ref side is analogous in LOAD_REF.
- LOAD_CUR: counter increments on each accepted word.
  - After word CUR_WORDS-1 (address 31) is accepted: counter clears and state goes to LOAD_REF.
- LOAD_REF: after word REF_WORDS-1 (address 127) is accepted, go to GO.
- in_valid gaps stall loading with no penalty; addresses never skip.
- GO: go = 1 for exactly one cycle, then WAIT; timeout counter clears.
- done edge detect: done_q <= done every cycle; done_evt = done & ~done_q. A done level held over from the previous block never qualifies.
- WAIT:
  - On done_evt: capture m_i/m_j into res_mi/res_mj, res_err = 0, go to RESULT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 without done_evt: res_mi = res_mj = 0, res_err = 1, go to RESULT.
  - If done_evt and timeout expiry coincide, done_evt wins (res_err = 0).
- RESULT:
  - res_valid = 1; res_idx = blk_idx; all res_* outputs stable while res_valid & ~res_ready.
  - On res_valid & res_ready, res_valid drops next cycle.
  - If blk_idx == num_blocks_latched - 1: job_done pulses for one cycle and state goes to IDLE.
  - Otherwise blk_idx increments and state goes to LOAD_CUR.
- No overlap: the memories are never written between GO and RESULT exit, because the engine reads them then.
- Minimum latency per block: 32 + 128 load cycles + 1 GO + engine time + 1 RESULT cycle.
- r is driven from latched cfg_r while busy and holds its last value in IDLE.
- Reset asserted mid-operation: immediate return to reset values. A partially loaded block is discarded, and no job_done pulse is produced.
- blk_idx is 16 bits; num_blocks = 65535 completes without wrap.

Decomposition:
- Shared package me_pkg:
  - state enum (IDLE..RESULT)
  - localparams CUR_WORDS = 32, REF_WORDS = 128, CA_WIDTH = 5, RA_WIDTH = 7, PIX_WIDTH = 64
- One natural sub-module, me_load_ctr: word counter with terminal-count flag and write-strobe generation, instantiated for the cur and ref sides. The FSM stays in the top.

Test Plan:
1. Reset low mid-LOAD_REF at word 50, then release: all outputs 0, state IDLE. A new start with num_blocks = 1 completes normally.
2. num_blocks = 1, cfg_r = 7, gap-free in_valid with in_data = address; engine model returns m_i = 8'h03, m_j = 8'hFD 20 cycles after go:
   - cur addresses 0..31 written, then ref 0..127
   - r = 7; exactly one go pulse
   - result {3, FD, idx 0, err 0}; job_done one cycle after the handshake
3. num_blocks = 3 with random in_valid gaps and res_ready held low for 10 cycles on block 1: res_* stable during the stall, no memory writes before the handshake, results returned with idx 0, 1, 2.
4. Engine never raises done, TIMEOUT = 16: result with res_err = 1 and m_i = m_j = 0 exactly 16 cycles after go; the next block proceeds.
5. done held high from the previous block through the next GO: no early capture; result taken only on the fresh 0→1 edge.
6. start pulsed while busy, and start with num_blocks = 0 while idle:
   - start while busy is ignored (busy unchanged, latched config unchanged)
   - num_blocks = 0 gives job_done one cycle later with no go, no writes and busy never set
